ingress_frame_buffer: RTL and testbench

//  Ingress stage of one switch port, fed directly by a port's frame source (valid-qualified beats + done strobe).

---
 rtl/ingress_frame_buffer_if.sv | 42 ++++
 rtl/ingress_frame_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_ingress_frame_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ingress_frame_buffer_if.sv
// Purpose: port-facing bundle of the ingress frame buffer (frame source, arbiter, frame output).
// Latency: none, wires only.
// Backpressure: none on the source side; the output side is paced by out_req/out_grant.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface ingress_frame_buffer_if #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);

    logic                  in_vaild;
    logic [WIDTH_SEL-1:0]  in_rx_port;
    logic [WIDTH_SEL-1:0]  in_tx_port;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_done;
    logic                  out_req;
    logic                  out_grant;
    logic                  out_vaild;
    logic [DATA_WIDTH-1:0] out_data;
    logic [WIDTH_SEL-1:0]  out_dest;
    logic [WIDTH_SEL-1:0]  out_src;
    logic                  out_last;
    logic                  drop_pulse;

    // Frame source and arbiter side.
    modport master (
        output in_vaild, in_rx_port, in_tx_port, in_data, in_done, out_grant,
        input  out_req, out_vaild, out_data, out_dest, out_src, out_last, drop_pulse
    );

    // Buffer side.
    modport slave (
        input  in_vaild, in_rx_port, in_tx_port, in_data, in_done, out_grant,
        output out_req, out_vaild, out_data, out_dest, out_src, out_last, drop_pulse
    );
endinterface

// File: rtl/ingress_frame_buffer.sv
// Purpose: collect one port's frame into a local FIFO, commit a descriptor, stream it out on grant; optional STATS_EN adds frame/drop counters.
// Latency: in_done at T -> out_req at T+2; grant at T+2 -> first beat at T+3.
// Backpressure: none on input (overflow / over-long frames drop atomically); output waits for out_grant.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

// Purpose: small generic synchronous FIFO with registered pointers.
// Latency: write visible at rd_dat the cycle after the push.
// Backpressure: full/empty flags; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    assign full   = (wp - rp) == (AW+1)'(DEPTH);
    assign empty  = (wp == rp);
    assign rd_dat = mem[rp[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_vld && !full) wp <= wp + 1'b1;
            if (rd_rdy && !empty) rp <= rp + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_vld && !full) mem[wp[AW-1:0]] <= wr_dat;
    end
endmodule

module ingress_frame_buffer #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int DESC_DEPTH = 4,
    parameter int MAX_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ingress_frame_buffer_if.slave bus
`ifdef STATS_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt
`endif
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);
    localparam int AW        = $clog2(DEPTH);
    localparam int LEN_W     = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [WIDTH_SEL-1:0] dest;
        logic [WIDTH_SEL-1:0] src;
        logic [LEN_W-1:0]     len;
    } desc_t;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr_spec, wptr_com, rptr;
    logic [LEN_W-1:0]      blen, blen_eff, remain;
    logic                  drop_flg, drop_eff, drop_pulse;
    logic [WIDTH_SEL-1:0]  cur_dest, cur_src, dest_q, src_q;
    logic                  data_full, beat_ok, beat_bad;
    logic                  done_drop, desc_push, desc_pop, desc_full, desc_empty;
    desc_t                 desc_wr, desc_rd;
    state_t                state, state_nxt;

    // Beat classification: a beat either lands in the FIFO or poisons the frame.
    always_comb begin
        data_full = (wptr_spec - rptr) == (AW+1)'(DEPTH);
        beat_ok   = bus.in_vaild && !drop_flg && !data_full && (blen != LEN_W'(MAX_LEN));
        beat_bad  = bus.in_vaild && !drop_flg && !beat_ok;
        drop_eff  = drop_flg || beat_bad;
        // A beat coinciding with in_done still belongs to the closing frame.
        blen_eff  = blen + LEN_W'(beat_ok);
        done_drop = bus.in_done && (drop_eff || ((blen_eff != '0) && desc_full));
        desc_push = bus.in_done && !drop_eff && (blen_eff != '0) && !desc_full;
        desc_wr.dest = (blen == '0) ? bus.in_rx_port : cur_dest;
        desc_wr.src  = (blen == '0) ? bus.in_tx_port : cur_src;
        desc_wr.len  = blen_eff;
    end

    // Write-side pointers: speculative advance per beat, commit or roll back on in_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_spec  <= '0;
            wptr_com   <= '0;
            blen       <= '0;
            drop_flg   <= 1'b0;
            cur_dest   <= '0;
            cur_src    <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= done_drop;
            if (bus.in_done) begin
                blen     <= '0;
                drop_flg <= 1'b0;
                if (done_drop) begin
                    wptr_spec <= wptr_com;
                end else begin
                    wptr_spec <= wptr_spec + (AW+1)'(beat_ok);
                    wptr_com  <= wptr_spec + (AW+1)'(beat_ok);
                end
            end else begin
                if (beat_ok) begin
                    wptr_spec <= wptr_spec + 1'b1;
                    blen      <= blen + 1'b1;
                    if (blen == '0) begin
                        cur_dest <= bus.in_rx_port;
                        cur_src  <= bus.in_tx_port;
                    end
                end
                if (beat_bad) drop_flg <= 1'b1;
            end
        end
    end

    // Payload storage write.
    always_ff @(posedge clk) begin
        if (beat_ok) mem[wptr_spec[AW-1:0]] <= bus.in_data;
    end

    sync_fifo #(.W($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (desc_push),
        .wr_dat (desc_wr),
        .rd_rdy (desc_pop),
        .rd_dat (desc_rd),
        .full   (desc_full),
        .empty  (desc_empty)
    );

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Read FSM next state and descriptor pop.
    always_comb begin
        state_nxt = state;
        desc_pop  = 1'b0;
        case (state)
            IDLE: if (!desc_empty) state_nxt = REQ;
            REQ: begin
                if (bus.out_grant) begin
                    desc_pop  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: if (remain == LEN_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read-side datapath: load frame on grant, then step through it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr   <= '0;
            remain <= '0;
            dest_q <= '0;
            src_q  <= '0;
        end else if (desc_pop) begin
            remain <= desc_rd.len;
            dest_q <= desc_rd.dest;
            src_q  <= desc_rd.src;
        end else if (state == SEND) begin
            rptr   <= rptr + 1'b1;
            remain <= remain - 1'b1;
        end
    end

    assign bus.out_req    = (state == REQ);
    assign bus.out_vaild  = (state == SEND);
    assign bus.out_last   = (state == SEND) && (remain == LEN_W'(1));
    assign bus.out_data   = (state == SEND) ? mem[rptr[AW-1:0]] : '0;
    assign bus.out_dest   = dest_q;
    assign bus.out_src    = src_q;
    assign bus.drop_pulse = drop_pulse;

`ifdef STATS_EN
    // Saturating committed/dropped frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (desc_push && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
            if (done_drop && drop_cnt != 16'hFFFF)  drop_cnt  <= drop_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ingress_frame_buffer.sv
// Purpose: directed bench for ingress_frame_buffer (PORT_NUB=8, DATA_WIDTH=16, DEPTH=16, MAX_LEN=16).
// Latency: checks the in_done -> out_req -> first beat timing directly.
// Backpressure: out_grant is driven by the bench to hold frames in the buffer.
module tb_ingress_frame_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ingress_frame_buffer_if bus ();
`ifdef STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    ingress_frame_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int drop_seen  = 0;
    int vaild_seen = 0;

    // Event counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.drop_pulse) drop_seen  <= drop_seen + 1;
        if (bus.out_vaild)  vaild_seen <= vaild_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n beats (data = base + step*i), then in_done. Port fields change after
    // the first beat to show they are latched only once. Returns in the cycle after in_done.
    task automatic send_frame(input int n, input logic [2:0] rx, input logic [2:0] tx,
                              input logic [15:0] base, input logic [15:0] step,
                              input bit done_with_last);
        for (int i = 0; i < n; i++) begin
            bus.in_vaild   = 1'b1;
            bus.in_data    = base + step * 16'(i);
            bus.in_rx_port = (i == 0) ? rx : ~rx;
            bus.in_tx_port = (i == 0) ? tx : ~tx;
            bus.in_done    = done_with_last && (i == n - 1);
            tick();
        end
        if (!done_with_last || n == 0) begin
            bus.in_vaild = 1'b0;
            bus.in_done  = 1'b1;
            tick();
        end
        bus.in_vaild = 1'b0;
        bus.in_done  = 1'b0;
    endtask

    // Wait for out_req (bounded), grant one cycle, check every beat of the frame.
    task automatic recv_frame(input string tag, input int n, input logic [2:0] rx,
                              input logic [2:0] tx, input logic [15:0] base,
                              input logic [15:0] step);
        int w;
        w = 0;
        while (!bus.out_req && w < 200) begin
            tick();
            w++;
        end
        check_eq({tag, "_req"}, 32'(bus.out_req), 32'd1);
        if (!bus.out_req) return;
        bus.out_grant = 1'b1;
        tick();
        bus.out_grant = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_beat"},
                     {8'd0, bus.out_vaild, bus.out_last, bus.out_dest, bus.out_src, bus.out_data},
                     {8'd0, 1'b1, 1'(i == n - 1), rx, tx, 16'(base + step * 16'(i))});
            tick();
        end
        check_eq({tag, "_end"}, 32'(bus.out_vaild), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int v0;
        int w;
        rst            = 1'b1;
        bus.in_vaild   = 1'b0;
        bus.in_rx_port = '0;
        bus.in_tx_port = '0;
        bus.in_data    = '0;
        bus.in_done    = 1'b0;
        bus.out_grant  = 1'b0;
        idle(2);
        check_eq("reset_outs",
                 {8'd0, bus.out_req, bus.out_vaild, bus.out_last, bus.drop_pulse, bus.out_dest, bus.out_src, bus.out_data},
                 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: 4 beats of 0x35 to port 5 from port 3; latency check.
        send_frame(4, 3'd5, 3'd3, 16'h0035, 16'h0000, 1'b0);
        check_eq("t1_req_T1", 32'(bus.out_req), 32'd0);
        tick();
        check_eq("t1_req_T2", 32'(bus.out_req), 32'd1);
        recv_frame("t1", 4, 3'd5, 3'd3, 16'h0035, 16'h0000);

        // 2: two 6-beat frames held; third overflows the 16-word buffer after 4 beats.
        send_frame(6, 3'd1, 3'd2, 16'h0100, 16'h0001, 1'b0);
        send_frame(6, 3'd2, 3'd4, 16'h0200, 16'h0001, 1'b0);
        d0 = drop_seen;
        send_frame(6, 3'd3, 3'd5, 16'h0300, 16'h0001, 1'b0);
        check_eq("t2_drop_pulse", 32'(bus.drop_pulse), 32'd1);
        idle(3);
        check_eq("t2_drop_once", 32'(drop_seen - d0), 32'd1);
        recv_frame("t2a", 6, 3'd1, 3'd2, 16'h0100, 16'h0001);
        recv_frame("t2b", 6, 3'd2, 3'd4, 16'h0200, 16'h0001);
        idle(5);
        check_eq("t2_no_third", 32'(bus.out_req), 32'd0);

        // 3: 17-beat frame is too long; a 2-beat frame with in_done on its last beat follows.
        send_frame(17, 3'd6, 3'd1, 16'h0400, 16'h0001, 1'b0);
        check_eq("t3_drop_pulse", 32'(bus.drop_pulse), 32'd1);
        idle(5);
        check_eq("t3_no_req", 32'(bus.out_req), 32'd0);
        send_frame(2, 3'd7, 3'd0, 16'h0500, 16'h0001, 1'b1);
        recv_frame("t3", 2, 3'd7, 3'd0, 16'h0500, 16'h0001);

        // 4: four frames fill the descriptor FIFO; the fifth is dropped.
        for (int f = 0; f < 4; f++)
            send_frame(3, 3'(f), 3'(7 - f), 16'h0600 + 16'(f * 16), 16'h0001, 1'b0);
        send_frame(2, 3'd6, 3'd6, 16'h0700, 16'h0001, 1'b0);
        check_eq("t4_drop_pulse", 32'(bus.drop_pulse), 32'd1);
        idle(40);
        check_eq("t4_req_held", 32'(bus.out_req), 32'd1);
        for (int f = 0; f < 4; f++)
            recv_frame("t4", 3, 3'(f), 3'(7 - f), 16'h0600 + 16'(f * 16), 16'h0001);
`ifdef STATS_EN
        check_eq("stats_frames", 32'(frame_cnt), 32'd8);
        check_eq("stats_drops", 32'(drop_cnt), 32'd3);
`endif

        // 5: reset while the second of six beats is on the output.
        send_frame(6, 3'd2, 3'd6, 16'h0800, 16'h0001, 1'b0);
        w = 0;
        while (!bus.out_req && w < 200) begin
            tick();
            w++;
        end
        check_eq("t5_req", 32'(bus.out_req), 32'd1);
        bus.out_grant = 1'b1;
        tick();
        bus.out_grant = 1'b0;
        tick();
        check_eq("t5_beat2", {15'd0, bus.out_vaild, bus.out_data}, {15'd0, 1'b1, 16'h0801});
        rst = 1'b1;
        #1;
        check_eq("t5_rst_outs",
                 {8'd0, bus.out_req, bus.out_vaild, bus.out_last, bus.drop_pulse, bus.out_dest, bus.out_src, bus.out_data},
                 32'd0);
        idle(2);
        rst = 1'b0;
        v0 = vaild_seen;
        idle(10);
        check_eq("t5_quiet", 32'(vaild_seen - v0), 32'd0);
        check_eq("t5_no_req", 32'(bus.out_req), 32'd0);
        send_frame(3, 3'd4, 3'd1, 16'h0900, 16'h0002, 1'b0);
        recv_frame("t5", 3, 3'd4, 3'd1, 16'h0900, 16'h0002);

        // 6: in_done with no beats is ignored.
        d0 = drop_seen;
        send_frame(0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);
        check_eq("t6_no_pulse", 32'(bus.drop_pulse), 32'd0);
        idle(5);
        check_eq("t6_no_req", 32'(bus.out_req), 32'd0);
        check_eq("t6_no_drop", 32'(drop_seen - d0), 32'd0);
`ifdef STATS_EN
        check_eq("stats_frames_post_rst", 32'(frame_cnt), 32'd1);
        check_eq("stats_drops_post_rst", 32'(drop_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
